// File: rtl/vid_capture_if.sv
// Memory-write port: a word address plus packed pixel data, moved on a valid/ready handshake.
// Latency: none; this interface only bundles the signals.
// Backpressure: the slave holds mem_ready low to stall; the master keeps addr/data stable until accepted.
interface vid_capture_if;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        mem_ready;

  modport master (output mem_addr, output mem_data, output mem_valid, input mem_ready);
  modport slave  (input mem_addr, input mem_data, input mem_valid, output mem_ready);
endinterface

// File: rtl/vid_capture.sv
// Captures one visible video frame on request, packing pixel pairs into 32-bit words for memory.
// Latency: pixel1 strobe at cycle N -> buffer write at N+1 -> mem_valid at N+2 (buffer empty).
// Backpressure: 8-deep write buffer; when full, words are dropped, counted and flagged as overflow.
// Optional build macro VID_CAPTURE_CHECKSUM_EN adds a capture_checksum output.

// Small synchronous FIFO; a push on a full FIFO is accepted only if a pop frees a slot that cycle.
module vid_capture_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = store_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage, pointers and occupancy; storage cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      if (do_push) begin
        store_q[wr_ptr_q] <= push_dat;
        wr_ptr_q          <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module vid_capture #(
  parameter int WORDS_PER_FRAME = 40960,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] vid_pixel,
  input  logic        vid_pixsync,
  input  logic        vid_hblank,
  input  logic        vid_vblank,
  input  logic        capture_start,
  output logic        capture_busy,
  output logic        capture_done,
  output logic        capture_short,
  output logic        capture_overflow,
`ifdef VID_CAPTURE_CHECKSUM_EN
  output logic [31:0] capture_checksum,
`endif
  vid_capture_if.master mem
);
  localparam logic [15:0] WPF = 16'(WORDS_PER_FRAME);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        vb_prev_q, vb_seen_q, half_q;
  logic [11:0] pix0_q;
  logic [15:0] cnt_q, cnt_inc;
  logic        short_q, ovf_q, done_q;
  logic        push_vld_q;
  logic [31:0] push_dat_q;
  logic [15:0] push_addr_q;

  logic        visible, frame_end, drained;
  logic        clr, take_pix0, take_pix1, end_push, set_short, done_d;
  logic        fifo_full, fifo_empty, mem_vld, mem_pop;
  logic [47:0] fifo_head;

  assign visible   = vid_pixsync && !vid_hblank && !vid_vblank;
  assign frame_end = vid_pixsync && vid_vblank && !vb_prev_q;
  assign cnt_inc   = cnt_q + 16'd1;
  assign drained   = fifo_empty && !push_vld_q;
  assign mem_vld   = !fifo_empty;
  assign mem_pop   = mem_vld && mem.mem_ready;

  assign mem.mem_valid = mem_vld;
  assign mem.mem_addr  = fifo_head[47:32];
  assign mem.mem_data  = fifo_head[31:0];

  assign capture_busy     = (state_q != IDLE);
  assign capture_done     = done_q;
  assign capture_short    = short_q;
  assign capture_overflow = ovf_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control strobes for the pixel packer.
  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    take_pix0 = 1'b0;
    take_pix1 = 1'b0;
    end_push  = 1'b0;
    set_short = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_start) begin
          clr     = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        // Only a pixel after a vblank sample may start the capture, so it is frame-aligned.
        if (vb_seen_q && visible) begin
          take_pix0 = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (visible) begin
          if (!half_q) begin
            take_pix0 = 1'b1;
          end else begin
            take_pix1 = 1'b1;
            if (cnt_inc == WPF) state_d = DRAIN;
          end
        end else if (frame_end) begin
          set_short = 1'b1;
          end_push  = half_q;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel packing, word counter, push pipeline register and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      vb_prev_q   <= 1'b0;
      vb_seen_q   <= 1'b0;
      half_q      <= 1'b0;
      pix0_q      <= '0;
      cnt_q       <= '0;
      short_q     <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      push_vld_q  <= 1'b0;
      push_dat_q  <= '0;
      push_addr_q <= '0;
    end else begin
      if (vid_pixsync) vb_prev_q <= vid_vblank;
      if (clr) begin
        vb_seen_q <= 1'b0;
        half_q    <= 1'b0;
        cnt_q     <= '0;
        short_q   <= 1'b0;
        ovf_q     <= 1'b0;
      end
      if (state_q == ARM && vid_pixsync && vid_vblank) vb_seen_q <= 1'b1;
      if (take_pix0) begin
        pix0_q <= vid_pixel;
        half_q <= 1'b1;
      end
      push_vld_q  <= take_pix1 || end_push;
      push_dat_q  <= take_pix1 ? {4'b0, vid_pixel, 4'b0, pix0_q} : {20'b0, pix0_q};
      push_addr_q <= cnt_q;
      // Dropped words still consume an address so later words stay frame-aligned.
      if (take_pix1 || end_push) begin
        cnt_q  <= cnt_inc;
        half_q <= 1'b0;
      end
      if (set_short) short_q <= 1'b1;
      if (push_vld_q && fifo_full && !mem_pop) ovf_q <= 1'b1;
      done_q <= done_d;
    end
  end

  vid_capture_fifo #(
    .WIDTH (48),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_vld_q),
    .push_dat ({push_addr_q, push_dat_q}),
    .pop      (mem_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (fifo_head)
  );

`ifdef VID_CAPTURE_CHECKSUM_EN
  logic [31:0] chk_q;
  assign capture_checksum = chk_q;

  // Running sum of words actually accepted by memory during the capture.
  always_ff @(posedge clk) begin
    if (rst || clr) chk_q <= '0;
    else if (mem_pop) chk_q <= chk_q + mem.mem_data;
  end
`endif
endmodule
